// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the N-core memory controller.
//   state_t     : controller state (IDLE, RD, WR)
//   *_DEF       : default lane count and widths
//   lsb_idx()   : index of the lowest set bit of a mask of up to 32 lanes
package mem_ctrl_pkg;

  localparam int N_CORES_DEF = 4;
  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  // Returns 0 for an all-zero mask; callers qualify with |mask.
  function automatic logic [4:0] lsb_idx(input logic [31:0] v);
    lsb_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lsb_idx = 5'(i);
    end
  endfunction

endpackage

// File: rtl/mem_ctrl_ncores_if.sv
// Core/sequencer and memory bus of mem_ctrl_ncores.
//   MRead/MWrite  : batch request pulses        MReady       : controller idle
//   en/addr/data  : per-core mask and lanes     q            : per-core read data
//   addr_mem/data_to_mem/wren : memory pins     data_from_mem: memory read data
// Modports: slave = controller, master = sequencer plus memory.
interface mem_ctrl_ncores_if
  import mem_ctrl_pkg::*;
#(
  parameter int N_CORES = N_CORES_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
);

  logic                  MRead;
  logic                  MWrite;
  logic                  MReady;
  logic [N_CORES-1:0]    en;
  logic [N_CORES*AW-1:0] addr;
  logic [N_CORES*DW-1:0] data;
  logic [N_CORES*DW-1:0] q;
  logic [DW-1:0]         data_to_mem;
  logic [AW-1:0]         addr_mem;
  logic [DW-1:0]         data_from_mem;
  logic                  wren;

  modport slave (
    input  MRead, MWrite, en, addr, data, data_from_mem,
    output MReady, q, data_to_mem, addr_mem, wren
  );

  modport master (
    output MRead, MWrite, en, addr, data, data_from_mem,
    input  MReady, q, data_to_mem, addr_mem, wren
  );

endinterface

// File: rtl/mem_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder over an N-bit request mask (N <= 32).
//   req_i : request mask
//   idx_o : index of the lowest set bit (0 when req_i is empty)
//   vld_o : at least one bit of req_i is set
module mem_ctrl_prio_enc
  import mem_ctrl_pkg::*;
#(
  parameter  int N  = N_CORES_DEF,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [4:0] idx_full;

  always_comb begin
    idx_full = lsb_idx(32'(req_i));
    idx_o    = idx_full[IW-1:0];
    vld_o    = |req_i;
  end

endmodule

// File: rtl/mem_ctrl_ncores.sv
// Arbitrates N cores onto one single-port synchronous memory. A single
// MRead/MWrite pulse latches all lanes and then services every enabled lane,
// one access per clock, in ascending core index.
// Ports:
//   clk      : clock (memory samples on the falling edge)
//   reset    : synchronous active-high reset, aborts a batch in progress
//   bus      : mem_ctrl_ncores_if.slave (request, lanes, q, memory pins)
//   busy_err : sticky late-request flag, present only with MEMCTRL_ERR_EN
module mem_ctrl_ncores
  import mem_ctrl_pkg::*;
#(
  parameter int N_CORES = N_CORES_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic clk,
  input  logic reset,
`ifdef MEMCTRL_ERR_EN
  output logic busy_err,
`endif
  mem_ctrl_ncores_if.slave bus
);

  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  state_t                state_q;
  logic                  mready_q;
  logic                  wren_q;
  logic [N_CORES-1:0]    pending_q;
  logic [N_CORES-1:0]    pending_d;
  logic [N_CORES*AW-1:0] addr_lat_q;
  logic [N_CORES*DW-1:0] data_lat_q;
  logic [N_CORES*DW-1:0] q_q;
  logic [AW-1:0]         addr_mem_q;
  logic [DW-1:0]         data_to_mem_q;

  logic [IW-1:0]         cur_idx;
  logic                  cur_vld;
  logic [IW-1:0]         nxt_idx;
  logic                  nxt_vld;
  logic [N_CORES-1:0]    nxt_src;
  logic [N_CORES*AW-1:0] addr_src;
  logic [N_CORES*DW-1:0] data_src;
  logic [AW-1:0]         addr_d;
  logic [DW-1:0]         data_d;

  // Lane being serviced this cycle.
  mem_ctrl_prio_enc #(.N(N_CORES)) u_enc_cur (
    .req_i (pending_q),
    .idx_o (cur_idx),
    .vld_o (cur_vld)
  );

  // Lane to be presented next cycle: the first enabled lane of a new batch
  // when idle, otherwise the next one left after the current lane retires.
  // The memory pins are registered from this so they are glitch-free and
  // hold their last value once the batch ends.
  mem_ctrl_prio_enc #(.N(N_CORES)) u_enc_nxt (
    .req_i (nxt_src),
    .idx_o (nxt_idx),
    .vld_o (nxt_vld)
  );

  always_comb begin
    pending_d = pending_q & ~(N_CORES'(1) << cur_idx);
    if (state_q == IDLE) begin
      nxt_src  = bus.en;
      addr_src = bus.addr;
      data_src = bus.data;
    end else begin
      nxt_src  = pending_d;
      addr_src = addr_lat_q;
      data_src = data_lat_q;
    end
    addr_d = addr_src[AW*nxt_idx +: AW];
    data_d = data_src[DW*nxt_idx +: DW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mready_q      <= 1'b1;
      wren_q        <= 1'b0;
      pending_q     <= '0;
      q_q           <= '0;
      addr_mem_q    <= '0;
      data_to_mem_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.MWrite || bus.MRead) begin
            addr_lat_q <= bus.addr;
            data_lat_q <= bus.data;
            pending_q  <= bus.en;
            // An empty mask is accepted but does nothing.
            if (nxt_vld) begin
              state_q       <= bus.MWrite ? WR : RD;
              mready_q      <= 1'b0;
              wren_q        <= bus.MWrite;
              addr_mem_q    <= addr_d;
              data_to_mem_q <= data_d;
            end
          end
        end
        RD, WR: begin
          if (state_q == RD && cur_vld) begin
            q_q[DW*cur_idx +: DW] <= bus.data_from_mem;
          end
          pending_q <= pending_d;
          if (nxt_vld) begin
            addr_mem_q    <= addr_d;
            data_to_mem_q <= data_d;
          end else begin
            state_q  <= IDLE;
            mready_q <= 1'b1;
            wren_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          mready_q <= 1'b1;
          wren_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEMCTRL_ERR_EN
  logic busy_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_err_q <= 1'b0;
    end else if (state_q != IDLE && (bus.MRead || bus.MWrite)) begin
      busy_err_q <= 1'b1;
    end
  end

  assign busy_err = busy_err_q;
`endif

  assign bus.MReady      = mready_q;
  assign bus.wren        = wren_q;
  assign bus.q           = q_q;
  assign bus.addr_mem    = addr_mem_q;
  assign bus.data_to_mem = data_to_mem_q;

endmodule

// File: tb/tb_mem_ctrl_ncores.sv
// Bench for mem_ctrl_ncores: a falling-edge memory model on the bus, a
// reference memory and expected-q scoreboard driven with each batch.
module tb_mem_ctrl_ncores;
  import mem_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk;
  logic reset;
  logic mem_clr;
`ifdef MEMCTRL_ERR_EN
  logic busy_err;
`endif

  mem_ctrl_ncores_if #(.N_CORES(N), .AW(AW), .DW(DW)) bus ();

  mem_ctrl_ncores #(.N_CORES(N), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef MEMCTRL_ERR_EN
    .busy_err (busy_err),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External memory, clocked on the falling edge.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rdata;

  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.wren) begin
      mem[bus.addr_mem[7:0]] <= bus.data_to_mem;
    end
    rdata <= mem[bus.addr_mem[7:0]];
  end

  assign bus.data_from_mem = rdata;

  // Reference state and scoreboard.
  logic [DW-1:0] mem_ref [0:255];
  logic [DW-1:0] exp_q   [0:N-1];
  logic [DW-1:0] sb_q [$];

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N*16-1:0] lanes(input logic [15:0] v0, input logic [15:0] v1,
                                            input logic [15:0] v2, input logic [15:0] v3);
    return {v3, v2, v1, v0};
  endfunction

  // mode: 0 plain, 1 scramble addr/data after accept, 2 late MWrite in cycle 2
  task automatic batch(input string tag, input logic wr, input logic rd,
                       input logic [N-1:0] m, input logic [N*AW-1:0] a,
                       input logic [N*DW-1:0] d, input int mode);
    int k;
    int lo;
    int wc;
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    k = 0;
    for (int i = 0; i < N; i++) if (m[i]) k++;
    if (m != '0) begin
      for (int i = 0; i < N; i++) begin
        if (m[i]) begin
          if (wr) mem_ref[a[AW*i +: 8]] = d[DW*i +: DW];
          else if (rd) exp_q[i] = mem_ref[a[AW*i +: 8]];
        end
      end
    end
    for (int i = 0; i < N; i++) sb_q.push_back(exp_q[i]);

    @(posedge clk); #1;
    bus.en = m; bus.addr = a; bus.data = d;
    bus.MWrite = wr; bus.MRead = rd;
    @(posedge clk); #1;
    bus.MWrite = 1'b0; bus.MRead = 1'b0;
    lo = 0;
    wc = 0;
    if (bus.wren) wc++;
    while (!bus.MReady && lo < 20) begin
      if (mode == 1 && lo == 0) begin
        bus.addr = ~a;
        bus.data = ~d;
      end
      if (mode == 2 && lo == 1) begin
        bus.MWrite = 1'b1;
        bus.addr   = lanes(16'd40, 16'd41, 16'd42, 16'd43);
        bus.data   = lanes(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      end
      if (mode == 2 && lo == 2) bus.MWrite = 1'b0;
      lo++;
      @(posedge clk); #1;
      if (!bus.MReady && bus.wren) wc++;
    end
    bus.MWrite = 1'b0;
    check({tag, "_busy_cycles"}, 64'(lo), 64'(k));
    check({tag, "_wren_cycles"}, 64'(wc), (wr && m != '0) ? 64'(k) : 64'd0);
    for (int i = 0; i < N; i++) begin
      want = sb_q.pop_front();
      got  = bus.q[DW*i +: DW];
      check($sformatf("%s_q%0d", tag, i), 64'(got), 64'(want));
    end
    if (wr && m != '0) begin
      for (int i = 0; i < N; i++) begin
        if (m[i]) check($sformatf("%s_mem%0d", tag, i),
                        64'(mem[a[AW*i +: 8]]), 64'(mem_ref[a[AW*i +: 8]]));
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    for (int i = 0; i < 256; i++) mem_ref[i] = '0;
    for (int i = 0; i < N; i++) exp_q[i] = '0;
    bus.MRead = 1'b0; bus.MWrite = 1'b0;
    bus.en = '0; bus.addr = '0; bus.data = '0;
    reset = 1'b1;
    mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mready", 64'(bus.MReady), 64'd1);
    check("rst_wren", 64'(bus.wren), 64'd0);
    check("rst_q", 64'(bus.q), 64'd0);
    check("rst_addr_mem", 64'(bus.addr_mem), 64'd0);
    check("rst_data_to_mem", 64'(bus.data_to_mem), 64'd0);
`ifdef MEMCTRL_ERR_EN
    check("rst_busy_err", 64'(busy_err), 64'd0);
`endif
    reset = 1'b0;
    mem_clr = 1'b0;

    batch("preload", 1'b1, 1'b0, 4'b1111, lanes(16'd10, 16'd11, 16'd12, 16'd13),
          lanes(16'hA0, 16'hA1, 16'hA2, 16'hA3), 0);
    batch("rd0110", 1'b0, 1'b1, 4'b0110, lanes(16'd10, 16'd11, 16'd12, 16'd13),
          lanes(16'h0, 16'h0, 16'h0, 16'h0), 0);
    batch("wr1111", 1'b1, 1'b0, 4'b1111, lanes(16'd20, 16'd21, 16'd22, 16'd23),
          lanes(16'd9, 16'd20, 16'd55, 16'd24), 1);
    batch("rdback", 1'b0, 1'b1, 4'b1111, lanes(16'd20, 16'd21, 16'd22, 16'd23),
          lanes(16'h0, 16'h0, 16'h0, 16'h0), 0);
    batch("empty", 1'b0, 1'b1, 4'b0000, lanes(16'd20, 16'd21, 16'd22, 16'd23),
          lanes(16'h0, 16'h0, 16'h0, 16'h0), 0);
    batch("both", 1'b1, 1'b1, 4'b0001, lanes(16'd5, 16'd0, 16'd0, 16'd0),
          lanes(16'd7, 16'd0, 16'd0, 16'd0), 0);
    check("both_mem5", 64'(mem[5]), 64'd7);

    batch("late_req", 1'b0, 1'b1, 4'b1111, lanes(16'd10, 16'd11, 16'd12, 16'd13),
          lanes(16'h0, 16'h0, 16'h0, 16'h0), 2);
    check("late_mem40", 64'(mem[40]), 64'd0);
    check("late_mem43", 64'(mem[43]), 64'd0);
`ifdef MEMCTRL_ERR_EN
    check("late_busy_err", 64'(busy_err), 64'd1);
`endif

    // Reset in cycle 2 of a 4-lane write.
    @(posedge clk); #1;
    bus.en = 4'b1111;
    bus.addr = lanes(16'd30, 16'd31, 16'd32, 16'd33);
    bus.data = lanes(16'h1230, 16'h1231, 16'h1232, 16'h1233);
    bus.MWrite = 1'b1;
    @(posedge clk); #1;
    bus.MWrite = 1'b0;
    check("mid_busy", 64'(bus.MReady), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_mready", 64'(bus.MReady), 64'd1);
    check("mid_rst_wren", 64'(bus.wren), 64'd0);
    check("mid_rst_q", 64'(bus.q), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("mid_idle_wren", 64'(bus.wren), 64'd0);
    end
    check("mid_mem30", 64'(mem[30]), 64'h1230);
    check("mid_mem32", 64'(mem[32]), 64'd0);
    check("mid_mem33", 64'(mem[33]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_ncores.md
Name: mem_ctrl_ncores

Overview:
- Arbitrates N GPU cores onto one single-port synchronous data memory.
- On one shared MRead or MWrite pulse, it services every enabled core in turn, one memory access per clock, in ascending core index.
- It drives the memory address, data and write-enable pins, and returns read data to per-core registers.
- MReady tells the sequencer when the whole batch is finished.

Parameters:
- N_CORES, 4, number of core lanes.
- AW, 16, address width per lane and to memory.
- DW, 16, data width per lane and to memory.

Ports:
- clk, input, 1: system clock. The memory is clocked on ~clk, so it samples at the falling edge.
- reset, input, 1: synchronous, active-high reset.
- MRead, input, 1: batch read request, single-cycle pulse.
- MWrite, input, 1: batch write request, single-cycle pulse.
- MReady, output, 1: high when idle; low while a batch is in progress.
- en, input, N_CORES: per-core participation mask.
- addr, input, N_CORES*AW: core i address in bits [AW*i +: AW].
- data, input, N_CORES*DW: core i write data in bits [DW*i +: DW].
- q, output, N_CORES*DW: core i registered read data in bits [DW*i +: DW].
- data_to_mem, output, DW: write data to memory.
- addr_mem, output, AW: memory address.
- data_from_mem, input, DW: memory read data. It is valid before the next rising clk edge after addr_mem is presented.
- wren, output, 1: memory write enable.

Behaviour:
- Reset (sync, active-high, highest priority, also aborts a batch in progress):
  - state=IDLE, MReady=1, pending mask=0.
  - All q lanes=0; addr_mem=0; data_to_mem=0; wren=0.
  - Any partial batch is discarded; memory writes already issued remain.
- States: IDLE, RD, WR.
- IDLE:
  - At a rising edge with MWrite=1 or MRead=1: latch en into pending, latch all addr and data lanes, and go to WR or RD. MWrite wins if both are high.
  - MReady goes 0 from that edge.
  - If the latched en==0, stay IDLE and keep MReady=1; no memory access occurs.
- Lane selection: idx = lowest set bit of pending, combinational from registered state.
  - addr_mem = latched addr[idx]; data_to_mem = latched data[idx].
- RD:
  - wren=0. Memory reads addr_mem at the falling edge.
  - At the next rising edge, q[idx] <= data_from_mem and pending[idx] is cleared.
- WR:
  - wren=1. Memory writes data_to_mem at the falling edge.
  - At the next rising edge, pending[idx] is cleared. q is unchanged.
- Completion: when pending becomes 0, go to IDLE with MReady=1 in the same edge. A batch of k enabled lanes therefore holds MReady low for exactly k cycles.
- In IDLE: wren=0; addr_mem and data_to_mem hold their last values.
- Lanes not enabled in a batch keep their previous q.
- MRead or MWrite arriving while not IDLE is ignored.
- Inputs may change freely after the accept edge, because all lanes were latched.
- Address wrap and out-of-range addresses are the memory's concern; the controller passes AW bits unmodified.

Optional Feature:
- Macro: MEMCTRL_ERR_EN.
- When defined: extra output busy_err (1 bit), sticky.
  - Set on any rising edge where MRead or MWrite=1 while state!=IDLE.
  - Cleared only by reset.
- When undefined: the port is absent and late requests are silently dropped.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - state enum (IDLE, RD, WR);
  - N_CORES, AW and DW defaults;
  - a lowest-set-bit helper function.
- One natural sub-module: mem_ctrl_prio_enc, an N_CORES-bit lowest-set-bit priority encoder producing idx and a valid flag.
- The datamem memory stays external.

Test Plan:
- Read batch. Preload mem[10..13]=A0,A1,A2,A3 and q=0. Set en=0110, addr=10,11,12,13, pulse MRead.
  - MReady is low for exactly 2 cycles.
  - q1=A1 and q2=A2; q0=q3=0.
- Write batch. Set en=1111, addr=20..23, data=9,20,55,24, pulse MWrite. Change addr and data on the cycle after the accept edge.
  - MReady is low for 4 cycles; wren is high for 4 cycles.
  - mem[20..23]=9,20,55,24.
  - Read back with en=1111 gives q=9,20,55,24.
- Empty mask and simultaneous requests:
  - en=0000 with MRead: MReady never drops and no wren.
  - MRead and MWrite high together with en=0001, addr=5, data=7: a write is performed, so mem[5]=7.
- Request while busy. Start a 4-lane read, then pulse MWrite in cycle 2.
  - The write is ignored and the read completes normally.
  - With MEMCTRL_ERR_EN defined, busy_err=1.
- Reset mid-batch. Assert reset during cycle 2 of a 4-lane write to addr 30..33.
  - Next edge: MReady=1, wren=0 and q=0.
  - mem[30] is written; mem[32..33] are untouched.
